// File: rtl/uart_rx_deser_param.sv
// ---------------------------------------------------------------------------
// uart_rx_deser_param
//
// Purpose:
//   UART RX deserializer sitting between the data sampler and the RX FSM.
//   Collects majority-voted bits, one per oversampled bit period, into a
//   parallel word. The frame length (5..DATA_WIDTH) and bit order (LSB- or
//   MSB-first) are taken at run time and held constant for the whole frame.
//   A completed frame is published on P_DATA together with a one-cycle
//   data_valid strobe.
//
// Optional feature:
//   UART_DESER_PARITY_EN - when defined, adds the par_calc output, which
//   holds the XOR of the last completed word and is updated alongside P_DATA.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous reset, active-low
//   deser_en     in   data phase enable from the RX FSM
//   sampled_bit  in   majority-voted bit from the data sampler
//   edge_cnt     in   oversampling edge counter within the current bit
//   prescale     in   oversampling ratio (edges per bit)
//   data_len     in   data bits per frame (clamped to DATA_WIDTH if illegal)
//   msb_first    in   0: LSB first, 1: MSB first
//   P_DATA       out  last completed word, unused upper bits zero
//   data_valid   out  one-cycle strobe when P_DATA is updated
//   busy         out  frame in progress
//   par_calc     out  XOR of last completed word (UART_DESER_PARITY_EN only)
// ---------------------------------------------------------------------------
module uart_rx_deser_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int LEN_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  busy
`ifdef UART_DESER_PARITY_EN
  ,
  output logic                  par_calc
`endif
);

  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [LEN_W-1:0]      bit_cnt;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      len_clamped;
  logic [LEN_W-1:0]      cur_len;
  logic [LEN_W-1:0]      last_idx;
  logic [LEN_W-1:0]      bit_idx;
  logic                  msb_q;
  logic                  cur_msb;
  logic                  cap;
  logic                  frame_done;

  // The first bit of a frame has to be placed using the live data_len and
  // msb_first, because the latched copies only become valid after that edge.
  // Every later bit uses the latched copies so mid-frame changes are ignored.
  always_comb begin
    cap = deser_en && (prescale != '0) && (edge_cnt == prescale - PRESCALE_W'(1));

    if ((data_len < LEN_W'(5)) || (data_len > LEN_W'(DATA_WIDTH)))
      len_clamped = LEN_W'(DATA_WIDTH);
    else
      len_clamped = data_len;

    cur_len  = (bit_cnt == '0) ? len_clamped : len_q;
    cur_msb  = (bit_cnt == '0) ? msb_first   : msb_q;
    last_idx = cur_len - LEN_W'(1);
    bit_idx  = cur_msb ? (last_idx - bit_cnt) : bit_cnt;

    // Drop the incoming bit into its slot and keep everything at or above
    // the frame length at zero so short frames read back zero-extended.
    asm_next = asm_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) == bit_idx)
        asm_next[i] = sampled_bit;
      if (LEN_W'(i) >= cur_len)
        asm_next[i] = 1'b0;
    end

    frame_done = cap && (bit_cnt == last_idx);
  end

  // Bit counter, assembly register and output registers. busy is updated
  // together with bit_cnt so it always equals (bit_cnt != 0) without lag.
  // The assembly register is cleared on completion and on abort so each
  // frame starts from an all-zero word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      asm_q      <= '0;
      bit_cnt    <= '0;
      len_q      <= LEN_W'(DATA_WIDTH);
      msb_q      <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_DESER_PARITY_EN
      par_calc   <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (cap) begin
        if (bit_cnt == '0) begin
          len_q <= len_clamped;
          msb_q <= msb_first;
        end
        if (frame_done) begin
          bit_cnt    <= '0;
          asm_q      <= '0;
          P_DATA     <= asm_next;
          data_valid <= 1'b1;
          busy       <= 1'b0;
`ifdef UART_DESER_PARITY_EN
          par_calc   <= ^asm_next;
`endif
        end else begin
          bit_cnt <= bit_cnt + LEN_W'(1);
          asm_q   <= asm_next;
          busy    <= 1'b1;
        end
      end else if (!deser_en && (bit_cnt != '0)) begin
        bit_cnt <= '0;
        asm_q   <= '0;
        busy    <= 1'b0;
      end
    end
  end

endmodule
